// File: rtl/wb_line_fetch.sv
// Wishbone pipelined read master: bursts one scanline of framebuffer words into a line buffer.
// Define LINE_FETCH_DOUBLE_EN for a two-bank buffer (fetch into one bank while the other is displayed).
module wb_line_fetch #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start,
    input  logic          abort,
    input  logic [31:0]   base_adr,
    input  logic [AW:0]   word_cnt,
    output logic          busy,
    output logic          done,
    output logic          cyc_o,
    output logic          stb_o,
    output logic [31:0]   adr_o,
    output logic          we_o,
    output logic [3:0]    sel_o,
    input  logic [31:0]   dat_i,
    input  logic          ack_i,
    input  logic          stall_i,
    input  logic [AW-1:0] rd_adr,
    output logic [31:0]   rd_dat
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
`ifdef LINE_FETCH_DOUBLE_EN
    localparam int IW = AW + 1;
`else
    localparam int IW = AW;
`endif

    state_t       state;
    logic [AW:0]  issued, acked, count;
    logic [AW:0]  count_in, acked_nx;
    logic         ack_ok, accept;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [31:0]  mem [0:(1<<IW)-1];

    assign we_o     = 1'b0;
    assign sel_o    = 4'hf;
    assign count_in = (word_cnt > DEPTH_W) ? DEPTH_W : word_cnt;
    // Acks only count while the cycle is open; stragglers after an abort fall on the floor.
    assign ack_ok   = cyc_o & ack_i;
    assign accept   = stb_o & ~stall_i;
    assign acked_nx = acked + {{AW{1'b0}}, ack_ok};

`ifdef LINE_FETCH_DOUBLE_EN
    logic wbank;
    assign wr_idx = {wbank, acked[AW-1:0]};
    assign rd_idx = {~wbank, rd_adr};
`else
    assign wr_idx = acked[AW-1:0];
    assign rd_idx = rd_adr;
`endif

    always_ff @(posedge clk_i) begin
        if (ack_ok) mem[wr_idx] <= dat_i;
    end

    // Registered read; a same-cycle write is not forwarded, so old data is returned.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rd_dat <= '0;
        else       rd_dat <= mem[rd_idx];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            cyc_o  <= 1'b0;
            stb_o  <= 1'b0;
            adr_o  <= '0;
            issued <= '0;
            acked  <= '0;
            count  <= '0;
`ifdef LINE_FETCH_DOUBLE_EN
            wbank  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (ack_ok) acked <= acked_nx;
            unique case (state)
                IDLE: if (start && !abort) begin
                    count  <= count_in;
                    issued <= '0;
                    acked  <= '0;
                    adr_o  <= base_adr & 32'hffff_fffc;
                    if (count_in == '0) begin
                        state <= DONE;
                    end else begin
                        state <= REQ;
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                REQ: if (accept) begin
                    issued <= issued + 1'b1;
                    adr_o  <= adr_o + 32'd4;
                    // Drop the strobe right after the last accepted request.
                    if (issued + 1'b1 == count) begin
                        stb_o <= 1'b0;
                        state <= DRAIN;
                    end
                end
                DRAIN: if (acked_nx == count) begin
                    cyc_o <= 1'b0;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
`ifdef LINE_FETCH_DOUBLE_EN
                    wbank <= ~wbank;
`endif
                end
                default: state <= IDLE;
            endcase
            if (abort && (state == REQ || state == DRAIN)) begin
                cyc_o <= 1'b0;
                stb_o <= 1'b0;
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule
